// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Port 0 is the instruction-fetch path and port 1 is the data-access path.
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam logic PORT_IFETCH = 1'b0;
  localparam logic PORT_DATA   = 1'b1;

  // Data accesses normally win. A starved fetch port overrides that.
  function automatic logic pick_winner(input logic req0,
                                       input logic req1,
                                       input logic starved);
    if (req0 && starved) return PORT_IFETCH;
    if (req1)            return PORT_DATA;
    return PORT_IFETCH;
  endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// BUSY-cycle watchdog for the memory arbiter.
// It is compiled only when MEM_ARB_TIMEOUT_EN is defined. expired is high on
// the TIMEOUT_CYCLES-th consecutive run cycle that has no clear.
`ifdef MEM_ARB_TIMEOUT_EN
module mem_arb_watchdog
  #(parameter int TIMEOUT_CYCLES = 255)
  (input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic clear,
   output logic expired);

  localparam int            CW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Count elapsed run cycles. Restart whenever the access ends or times out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run || clear || expired) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = run && (cnt == LAST);

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Two-port (instruction fetch / data) arbiter for one shared memory port.
// It uses an IDLE/BUSY FSM, and every output is a flop.
// Port 1 normally wins. Port 0 is forced once it has lost STARVE_LIMIT
// consecutive grants to port 1.
// Optional timeout: define MEM_ARB_TIMEOUT_EN to abort an access after
// TIMEOUT_CYCLES BUSY cycles without mem_ready (err pulse instead of done).
module mem_port_arbiter
  import mem_arb_pkg::*;
  #(parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 255)
  (input  logic clk,
   input  logic rst_n,
   input  logic req0,
   input  logic req1,
   input  logic mem_ready,
   output logic sel,
   output logic mem_req,
   output logic gnt0,
   output logic gnt1,
   output logic done0,
   output logic done1,
   output logic err0,
   output logic err1,
   output logic busy);

  localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

  arb_state_t state, state_nx;
  logic       sel_nx, mem_req_nx, gnt0_nx, gnt1_nx, done0_nx, done1_nx;
  logic [2:0] starve_cnt, starve_cnt_nx;
  logic       winner;

`ifdef MEM_ARB_TIMEOUT_EN
  logic expired;
  logic err0_nx, err1_nx;

  mem_arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (state == BUSY),
    .clear   (mem_ready),
    .expired (expired)
  );
`else
  // TIMEOUT_CYCLES matters only when the watchdog is built in.
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT_CYCLES > 0);
`endif

  assign winner = pick_winner(req0, req1, starve_cnt == STARVE_MAX);
  assign busy   = (state == BUSY);

  // Next-state, next-output and starvation-count logic.
  always_comb begin
    state_nx      = state;
    sel_nx        = sel;
    mem_req_nx    = mem_req;
    gnt0_nx       = gnt0;
    gnt1_nx       = gnt1;
    done0_nx      = 1'b0;
    done1_nx      = 1'b0;
    starve_cnt_nx = starve_cnt;
`ifdef MEM_ARB_TIMEOUT_EN
    err0_nx       = 1'b0;
    err1_nx       = 1'b0;
`endif
    case (state)
      IDLE: begin
        // mem_ready is ignored here. Any request starts an access.
        if (req0 || req1) begin
          state_nx   = BUSY;
          sel_nx     = winner;
          mem_req_nx = 1'b1;
          gnt0_nx    = (winner == PORT_IFETCH);
          gnt1_nx    = (winner == PORT_DATA);
          if (winner == PORT_IFETCH) begin
            starve_cnt_nx = '0;
          end else if (req0 && (starve_cnt != STARVE_MAX)) begin
            starve_cnt_nx = starve_cnt + 3'd1;
          end
        end
      end
      BUSY: begin
        // The owner's req is not watched here: an access always runs to the end.
        if (mem_ready) begin
          state_nx   = IDLE;
          mem_req_nx = 1'b0;
          gnt0_nx    = 1'b0;
          gnt1_nx    = 1'b0;
          done0_nx   = (sel == PORT_IFETCH);
          done1_nx   = (sel == PORT_DATA);
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (expired) begin
          state_nx   = IDLE;
          mem_req_nx = 1'b0;
          gnt0_nx    = 1'b0;
          gnt1_nx    = 1'b0;
          err0_nx    = (sel == PORT_IFETCH);
          err1_nx    = (sel == PORT_DATA);
        end
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and output registers. Reset abandons any access without a pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel        <= PORT_IFETCH;
      mem_req    <= 1'b0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      starve_cnt <= '0;
    end else begin
      state      <= state_nx;
      sel        <= sel_nx;
      mem_req    <= mem_req_nx;
      gnt0       <= gnt0_nx;
      gnt1       <= gnt1_nx;
      done0      <= done0_nx;
      done1      <= done1_nx;
      starve_cnt <= starve_cnt_nx;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  // Timeout error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err0 <= 1'b0;
      err1 <= 1'b0;
    end else begin
      err0 <= err0_nx;
      err1 <= err1_nx;
    end
  end
`else
  assign err0 = 1'b0;
  assign err1 = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter.
// It runs directed table vectors, hand-written corner sequences, and random
// traffic checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int STARVE = 4;
  localparam int TO     = 8;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, req0, req1, mem_ready;
  logic sel, mem_req, gnt0, gnt1, done0, done1, err0, err1, busy;
  logic [8:0] outs;

  int n_checks = 0;
  int n_pass   = 0;

  mem_port_arbiter #(.STARVE_LIMIT(STARVE), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .mem_ready(mem_ready),
    .sel(sel), .mem_req(mem_req), .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1), .err0(err0), .err1(err1), .busy(busy)
  );

  always #5 clk = ~clk;

  // Output bits: {sel, mem_req, gnt0, gnt1, done0, done1, err0, err1, busy}
  assign outs = {sel, mem_req, gnt0, gnt1, done0, done1, err0, err1, busy};

  // Transaction-level reference model.
  bit     m_busy;
  int     m_owner, m_age, m_starve;
  bit     m_sel;
  bit [1:0] m_done, m_err;

  function automatic logic [8:0] model_vec();
    return {m_sel, m_busy, (m_busy && m_owner == 0), (m_busy && m_owner == 1),
            m_done[0], m_done[1], m_err[0], m_err[1], m_busy};
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_age = 0; m_starve = 0; m_sel = 0;
    m_done = 0; m_err = 0;
  endtask

  task automatic model_edge(input bit r0, input bit r1, input bit mr);
    int w;
    m_done = 0;
    m_err  = 0;
    if (!m_busy) begin
      if (r0 || r1) begin
        if (r0 && m_starve == STARVE) w = 0;
        else if (r1)                  w = 1;
        else                          w = 0;
        if (w == 0)                          m_starve = 0;
        else if (r0 && m_starve < STARVE)    m_starve = m_starve + 1;
        m_busy  = 1;
        m_owner = w;
        m_sel   = (w == 1);
        m_age   = 0;
      end
    end else begin
      m_age = m_age + 1;
      if (mr) begin
        m_busy = 0;
        m_done[m_owner] = 1'b1;
      end else if (TO_EN && m_age == TO) begin
        m_busy = 0;
        m_err[m_owner] = 1'b1;
      end
    end
  endtask

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %b expected %b", name, act, exp);
    else n_pass++;
  endtask

  // Drive inputs, take one edge, advance the model, and settle 1ns past the edge.
  task automatic step(input logic r0, input logic r1, input logic mr);
    req0 = r0; req1 = r1; mem_ready = mr;
    @(posedge clk);
    model_edge(r0, r1, mr);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("reset_outputs", outs, 9'b0);
    check("reset_starve", {6'b0, dut.starve_cnt}, 9'd0);
    rst_n = 1'b1;
  endtask

  typedef struct packed {
    logic       r0;
    logic       r1;
    logic       mr;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl [15];

  initial begin
    int         grants [$];
    int         exp_order [10];
    logic       prev_req;
    int         k;
    logic [8:0] seq_val;

    // Scenario 1 (rows 0-4), port-1 drop mid-BUSY (5-9), back-to-back port 0 (10-14).
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 9'b011000001};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 9'b011000001};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 9'b011000001};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 9'b000010000};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 9'b000000000};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 9'b110100001};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 9'b110100001};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 9'b110100001};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 9'b100001000};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 9'b100000000};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 9'b011000001};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 9'b000010000};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 9'b011000001};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 9'b000010000};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 9'b000000000};
    exp_order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    do_reset();
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].r0, tbl[i].r1, tbl[i].mr);
      check($sformatf("table_row%0d", i), outs, tbl[i].exp);
      if (i == 3) check("s1_starve_zero", {6'b0, dut.starve_cnt}, 9'd0);
    end

    // Scenario 2: both requesting continuously, ready every BUSY cycle.
    do_reset();
    prev_req = 1'b0;
    for (int c = 0; c < 40 && grants.size() < 10; c++) begin
      step(1'b1, 1'b1, 1'b1);
      check("s2_cycle", outs, model_vec());
      if (mem_req && !prev_req) grants.push_back(int'(sel));
      prev_req = mem_req;
    end
    check("s2_grant_count", 9'(grants.size()), 9'd10);
    for (int i = 0; i < 10 && i < grants.size(); i++)
      check($sformatf("s2_grant%0d", i), 9'(grants[i]), 9'(exp_order[i]));

    // Scenario 4: asynchronous reset in the middle of a port-1 access.
    do_reset();
    step(1'b0, 1'b1, 1'b0);
    check("s4_grant", outs, 9'b110100001);
    step(1'b0, 1'b1, 1'b0);
    #3 rst_n = 1'b0;
    #1 check("s4_async_clear", outs, 9'b0);
    model_reset();
    mem_ready = 1'b1;
    @(posedge clk);
    #2 check("s4_held_no_done", outs, 9'b0);
    rst_n = 1'b0;
    rst_n = 1'b1;
    step(1'b0, 1'b1, 1'b0);
    check("s4_regrant", outs, 9'b110100001);
    step(1'b0, 1'b1, 1'b1);
    check("s4_done_after", outs, model_vec());

`ifdef MEM_ARB_TIMEOUT_EN
    // Scenario 5: no mem_ready, so err1 follows the 8th BUSY cycle.
    do_reset();
    step(1'b0, 1'b1, 1'b0);
    k = 21;
    for (int c = 1; c <= 20; c++) begin
      step(1'b0, 1'b1, 1'b0);
      if (err1) begin
        k = c;
        break;
      end
    end
    check("s5_timeout_cycles", 9'(k), 9'(TO));
    check("s5_err1_pulse", outs, 9'b100000010);
    step(1'b0, 1'b0, 1'b0);
    check("s5_idle_after", outs, 9'b100000000);

    // Scenario 6: mem_ready on BUSY cycle 8 wins over the timeout.
    do_reset();
    step(1'b0, 1'b1, 1'b0);
    for (int c = 1; c < TO; c++) step(1'b0, 1'b1, 1'b0);
    check("s6_still_busy", outs, 9'b110100001);
    step(1'b0, 1'b1, 1'b1);
    check("s6_done_not_err", outs, 9'b100001000);
`endif

    // Random traffic against the reference model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (c == 200) do_reset();
      step(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 60),
           1'($urandom_range(0, 2) == 0));
      seq_val = model_vec();
      check("rand_outputs", outs, seq_val);
      check("rand_starve", {6'b0, dut.starve_cnt}, 9'(m_starve));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
